fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: imem_req  out  1  fetch request to instruction memory.
REQ-004 SHALL provide: imem_addr  out  16  byte address of the requested instruction.
REQ-005 SHALL provide: imem_rdy  in  1  memory returns data this cycle; sampled only while imem_req=1.
REQ-006 SHALL provide: imem_data  in  16  instruction word, valid when imem_rdy=1.
REQ-007 SHALL provide: instr  out  16  held instruction to the decode control unit.
REQ-008 SHALL provide: instr_valid  out  1  instr holds a fetched, unconsumed instruction.
REQ-009 SHALL provide: stall  in  1  decode cannot accept; consume = instr_valid & ~stall.
REQ-010 SHALL provide: pc, pc_plus2  out  16 each  address of instr and that address + 2.
REQ-011 SHALL provide: branch_taken, is_b_instr, is_br_instr, hlt  in  1 each  decoded from instr; qualified by instr_valid.
REQ-012 SHALL provide: br_reg_data  in  16  register-operand target for the BR instruction.
REQ-013 SHALL provide: halted  out  1  fetch stopped by HLT; misalign  out  1  misaligned target fault.

Function
REQ-014 SHALL implement states FETCH, HOLD, HALT.
REQ-015 FETCH: SHALL drive imem_req=1, imem_addr=pc; on imem_rdy=1 capture imem_data into instr, enter HOLD; otherwise remain, address unchanged.
REQ-016 HOLD: SHALL drive instr_valid=1, imem_req=0; instr and pc SHALL stay constant while stall=1.
REQ-017 On consume with hlt=1: SHALL enter HALT; pc unchanged; takes priority over branch_taken.
REQ-018 On consume with branch_taken=1, is_b_instr=1: next pc SHALL = pc_plus2 + (sign-extended instr[8:0] shifted left 1), modulo 2^16.
REQ-019 On consume with branch_taken=1, is_br_instr=1: next pc SHALL = br_reg_data.
REQ-020 On consume otherwise: next pc SHALL = pc_plus2, wrapping 0xFFFE -> 0x0000; then enter FETCH.
REQ-021 Branch inputs SHALL be ignored whenever instr_valid=0 or stall=1.
REQ-022 HALT: SHALL hold halted=1, instr_valid=0, imem_req=0 until reset; all other inputs ignored.
REQ-023 pc_plus2 SHALL be combinational pc + 2 at all times.
REQ-024 Minimum throughput SHALL be one instruction per 2 cycles (imem_rdy in first FETCH cycle, no stall).
REQ-025 stall=1 in FETCH SHALL NOT block the request; stall affects only HOLD.

Reset
REQ-026 rst_n=0 SHALL immediately force state FETCH, pc=0x0000, instr=0x0000, instr_valid=0, halted=0, misalign=0.
REQ-027 imem_req SHALL be 0 while rst_n=0 and assert in the first cycle after release.
REQ-028 Reset during an outstanding request SHALL abandon it; a late imem_rdy/imem_data SHALL be ignored unless imem_req=1.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN defined: a next pc with bit0=1 SHALL enter HALT with misalign=1 and halted=1, pc = faulting target.
REQ-030 Macro undefined: next pc bit0 SHALL be forced to 0 and misalign SHALL be tied 0.

Verification
REQ-031 Reset release, imem_rdy=1 always, imem_data=0x0123, stall=0 -> imem_addr sequence 0x0000, 0x0002, 0x0004 on cycles 1, 3, 5.
REQ-032 instr=0xC1FE (B, imm9=0x1FE) at pc=0x0010, branch_taken=1, is_b_instr=1 -> next imem_addr 0x000E.
REQ-033 BR at pc=0x0020, branch_taken=1, is_br_instr=1, br_reg_data=0x0100 -> next imem_addr 0x0100; branch_taken=0 -> 0x0022.
REQ-034 stall=1 held 3 cycles in HOLD -> instr, pc, instr_valid=1 unchanged; no imem_req; fetch resumes the cycle after stall falls.
REQ-035 instr=0xF000 consumed with hlt=1 -> halted=1, instr_valid=0, imem_req=0 indefinitely; rst_n pulse -> pc=0x0000, fetch resumes.
REQ-036 With FETCH_ALIGN_CHECK_EN: BR with br_reg_data=0x0101 -> misalign=1, halted=1; without macro -> next imem_addr 0x0100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one 16-bit instruction at a time, holds it for
// decode, then steps, branches or halts. FETCH_ALIGN_CHECK_EN turns odd targets into a halt fault.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  input  logic        branch_taken,
  input  logic        is_b_instr,
  input  logic        is_br_instr,
  input  logic        hlt,
  input  logic [15:0] br_reg_data,
  output logic        halted,
  output logic        misalign,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] b_offset;
  logic [15:0] target;

  // Handshakes: memory transfers when imem_req & imem_rdy in the same cycle;
  // decode takes the held instruction when instr_valid & ~stall in the same cycle.
  assign imem_req    = (state_q == S_FETCH) & rst_n;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign pc          = pc_q;
  assign pc_plus2    = pc_q + 16'd2;
  assign halted      = (state_q == S_HALT);
  assign fsm_state   = state_q;

  // B offset: signed 9-bit halfword displacement relative to pc + 2.
  assign b_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};

  always_comb begin
    target = pc_plus2;
    if (branch_taken && is_b_instr)
      target = pc_plus2 + b_offset;
    else if (branch_taken && is_br_instr)
      target = br_reg_data;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (imem_rdy) begin
          instr_d = imem_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (hlt) begin
            state_d = S_HALT;
          end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            pc_d = target;
            if (target[0]) begin
              misalign_d = 1'b1;
              state_d    = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
`else
            pc_d    = target & 16'hFFFE;
            state_d = S_FETCH;
`endif
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, B/BR branches, stall, halt, reset
// and target alignment, with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        branch_taken;
  logic        is_b_instr;
  logic        is_br_instr;
  logic        hlt;
  logic [15:0] br_reg_data;
  logic        halted;
  logic        misalign;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdy     (imem_rdy),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .branch_taken (branch_taken),
    .is_b_instr   (is_b_instr),
    .is_br_instr  (is_br_instr),
    .hlt          (hlt),
    .br_reg_data  (br_reg_data),
    .halted       (halted),
    .misalign     (misalign),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; checks and new inputs happen 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_branch();
    branch_taken = 1'b0;
    is_b_instr   = 1'b0;
    is_br_instr  = 1'b0;
    hlt          = 1'b0;
    br_reg_data  = 16'h0000;
  endtask

  // From FETCH: memory answers in the first request cycle.
  task automatic fetch(input logic [15:0] d);
    imem_rdy  = 1'b1;
    imem_data = d;
    tick();
    imem_rdy  = 1'b0;
    imem_data = 16'h0000;
  endtask

  // From HOLD: decode takes the instruction with the given branch decode.
  task automatic consume(input logic bt, input logic isb, input logic isbr,
                         input logic h, input logic [15:0] brd);
    stall        = 1'b0;
    branch_taken = bt;
    is_b_instr   = isb;
    is_br_instr  = isbr;
    hlt          = h;
    br_reg_data  = brd;
    tick();
    clear_branch();
  endtask

  initial begin
    rst_n     = 1'b0;
    imem_rdy  = 1'b0;
    imem_data = 16'h0000;
    stall     = 1'b0;
    clear_branch();

    // Reset state, and a memory response during reset is dropped.
    #3;
    chk("rst_req", imem_req, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc2", pc_plus2, 16'h0002);
    chk("rst_valid", instr_valid, 16'd0);
    chk("rst_halted", halted, 16'd0);
    chk("rst_misalign", misalign, 16'd0);
    imem_rdy  = 1'b1;
    imem_data = 16'hBEEF;
    tick();
    chk("rst_late_rdy_instr", instr, 16'h0000);
    chk("rst_state", fsm_state, 16'd0);
    imem_rdy  = 1'b0;
    imem_data = 16'h0000;
    rst_n     = 1'b1;
    #1;
    chk("rel_req", imem_req, 16'd1);
    chk("rel_addr0", imem_addr, 16'h0000);

    // Sequential stream at one instruction per two cycles.
    fetch(16'h0123);
    chk("seq_valid", instr_valid, 16'd1);
    chk("seq_instr", instr, 16'h0123);
    chk("seq_hold_req", imem_req, 16'd0);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("seq_addr2", imem_addr, 16'h0002);
    chk("seq_req2", imem_req, 16'd1);
    fetch(16'h0123);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("seq_addr4", imem_addr, 16'h0004);

    // BR to 0x0010, then backward B with imm9=0x1FE: 0x0012 - 4 = 0x000E.
    fetch(16'h0123);
    consume(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010);
    chk("br_to_10", imem_addr, 16'h0010);
    fetch(16'hC1FE);
    chk("b_pc2", pc_plus2, 16'h0012);
    consume(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("b_back", imem_addr, 16'h000E);
    // Forward B imm9=5 at 0x000E: 0x0010 + 10 = 0x001A.
    fetch(16'hC005);
    consume(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("b_fwd", imem_addr, 16'h001A);

    // BR at 0x0020: not taken steps to 0x0022, taken goes to 0x0100.
    fetch(16'h0123);
    consume(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020);
    fetch(16'h0123);
    consume(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
    chk("br_not_taken", imem_addr, 16'h0022);
    fetch(16'h0123);
    consume(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020);
    fetch(16'h0123);
    consume(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100);
    chk("br_taken", imem_addr, 16'h0100);

    // Stall held three cycles in HOLD with branch/halt inputs that must be ignored.
    fetch(16'h4567);
    stall        = 1'b1;
    branch_taken = 1'b1;
    is_br_instr  = 1'b1;
    br_reg_data  = 16'h3000;
    hlt          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, 16'h4567);
      chk("stall_pc", pc, 16'h0100);
      chk("stall_valid", instr_valid, 16'd1);
      chk("stall_req", imem_req, 16'd0);
      chk("stall_halted", halted, 16'd0);
    end
    clear_branch();
    stall = 1'b0;
    tick();
    chk("stall_resume_req", imem_req, 16'd1);
    chk("stall_resume_addr", imem_addr, 16'h0102);

    // In FETCH: stall and decode inputs do not block or redirect; no rdy keeps the address.
    stall        = 1'b1;
    branch_taken = 1'b1;
    is_br_instr  = 1'b1;
    br_reg_data  = 16'h5555;
    hlt          = 1'b1;
    tick();
    chk("fetch_wait_addr", imem_addr, 16'h0102);
    chk("fetch_wait_req", imem_req, 16'd1);
    chk("fetch_ign_halted", halted, 16'd0);
    clear_branch();
    fetch(16'h2222);
    chk("fetch_stall_valid", instr_valid, 16'd1);
    chk("fetch_stall_instr", instr, 16'h2222);
    stall = 1'b0;

    // HLT wins over a taken branch; halt persists against any input.
    consume(1'b1, 1'b0, 1'b1, 1'b1, 16'h0800);
    chk("halt_halted", halted, 16'd1);
    chk("halt_valid", instr_valid, 16'd0);
    chk("halt_pc", pc, 16'h0102);
    for (int i = 0; i < 4; i++) begin
      imem_rdy     = 1'b1;
      imem_data    = 16'hF000;
      branch_taken = 1'b1;
      is_b_instr   = 1'b1;
      tick();
      chk("halt_hold_req", imem_req, 16'd0);
      chk("halt_hold_halted", halted, 16'd1);
      chk("halt_hold_pc", pc, 16'h0102);
    end
    clear_branch();

    // Asynchronous reset clears halt and abandons the late response.
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", halted, 16'd0);
    chk("rst2_pc", pc, 16'h0000);
    chk("rst2_req", imem_req, 16'd0);
    chk("rst2_instr", instr, 16'h0000);
    tick();
    chk("rst2_instr_late", instr, 16'h0000);
    imem_rdy  = 1'b0;
    imem_data = 16'h0000;
    rst_n     = 1'b1;
    #1;
    chk("rst2_resume_req", imem_req, 16'd1);
    chk("rst2_resume_addr", imem_addr, 16'h0000);

    // Sequential wrap 0xFFFE -> 0x0000.
    fetch(16'h0123);
    consume(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE);
    chk("wrap_pre", imem_addr, 16'hFFFE);
    chk("wrap_pc2", pc_plus2, 16'h0000);
    fetch(16'h0123);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wrap_post", imem_addr, 16'h0000);

    // Odd BR target.
    fetch(16'h0123);
    consume(1'b1, 1'b0, 1'b1, 1'b0, 16'h0101);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_misalign", misalign, 16'd1);
    chk("mis_halted", halted, 16'd1);
    chk("mis_pc", pc, 16'h0101);
    chk("mis_req", imem_req, 16'd0);
`else
    chk("mis_misalign", misalign, 16'd0);
    chk("mis_halted", halted, 16'd0);
    chk("mis_addr", imem_addr, 16'h0100);
    chk("mis_req", imem_req, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
